// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared constants and types for the integer register file slice.
//   XLEN_DEFAULT  : default data width
//   NREGS_DEFAULT : default number of architectural registers
//   REG_AW        : register index width for the default register count
//   reg_idx_t     : register index type
//   word_t        : data word type
//   pend_max()    : largest value a pending counter of a given width holds
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_AW        = $clog2(NREGS_DEFAULT);

    typedef logic [REG_AW-1:0]       reg_idx_t;
    typedef logic [XLEN_DEFAULT-1:0] word_t;

    function automatic int pend_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/rv32i_sb_counter.sv
// ---------------------------------------------------------------------------
// rv32i_sb_counter
//   Per-register pending-write counter for the register file scoreboard.
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   inc        : a destination claim was accepted for this register
//   dec        : a write to this register is retiring
//   clr        : discard all pending claims (dominates inc/dec)
//   count      : current number of outstanding writes
//   at_max     : count is at its saturation value
//   at_zero    : count is zero
//   underflow  : a retirement arrived while count is zero
// The counter never wraps: increments at max and decrements at zero are
// ignored; the owner is expected to prevent the former and flag the latter.
// ---------------------------------------------------------------------------
module rv32i_sb_counter
    import rv32i_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] count,
    output logic              at_max,
    output logic              at_zero,
    output logic              underflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

    logic [PEND_W-1:0] count_reg;
    logic [PEND_W-1:0] count_next;

    assign count     = count_reg;
    assign at_max    = (count_reg == CNT_MAX);
    assign at_zero   = (count_reg == '0);
    assign underflow = dec && at_zero;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !dec && !at_max) begin
            count_next = count_reg + PEND_W'(1);
        end else if (dec && !inc && !at_zero) begin
            count_next = count_reg - PEND_W'(1);
        end
        // inc && dec together: one write issued, one retired, net zero.
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rv32i_regfile_sb.sv
// ---------------------------------------------------------------------------
// rv32i_regfile_sb
//   Multi-read-port integer register file with write-to-read bypass and a
//   per-register pending-write scoreboard. ID reads operands and claims
//   destinations; WB retires writes; rd_busy exposes RAW hazards to ID.
//   clk         : rising-edge clock
//   reset       : synchronous, active-low
//   rd_reg      : NRD read indices
//   rd_data     : NRD read words (combinational, x0 reads zero)
//   rd_busy     : NRD flags, register has an unresolved pending write
//   issue_en    : claim issue_reg as a destination this cycle
//   issue_reg   : destination being claimed
//   issue_ready : claim accepted this cycle (combinational)
//   wb_enable   : retire a write this cycle
//   wb_reg      : register written
//   wb_data     : data written
//   flush       : discard all pending claims
//   sb_err      : sticky flag, retirement to a register with nothing pending
// ---------------------------------------------------------------------------
module rv32i_regfile_sb
    import rv32i_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NRD-1:0][AW-1:0]    rd_reg,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic                      issue_en,
    input  logic [AW-1:0]             issue_reg,
    output logic                      issue_ready,
    input  logic                      wb_enable,
    input  logic [AW-1:0]             wb_reg,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      flush,
    output logic                      sb_err
);

    // Register storage; x0 has no storage and reads as zero.
    logic [XLEN-1:0] regs_reg [1:NREGS-1];

    logic [NREGS-1:0][PEND_W-1:0] pend_cnt;
    logic [NREGS-1:0]             at_max_vec;
    logic [NREGS-1:0]             at_zero_vec;
    logic [NREGS-1:0]             underflow_vec;

    logic claim_ok;
    logic wb_to_issue;
    logic sb_err_reg;

    // -----------------------------------------------------------------------
    // Write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_enable && (wb_reg != '0)) begin
            regs_reg[wb_reg] <= wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Claim acceptance. A register at its limit can still be claimed when a
    // write to it retires in the same cycle, since the count nets out.
    // -----------------------------------------------------------------------
    assign wb_to_issue = wb_enable && (wb_reg == issue_reg);
    assign issue_ready = (issue_reg == '0) || !(at_max_vec[issue_reg] && !wb_to_issue);
    assign claim_ok    = issue_en && issue_ready && !flush;

    // -----------------------------------------------------------------------
    // Pending-write counters, one per writable register
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pend_cnt[gi]      = '0;
                assign at_max_vec[gi]    = 1'b0;
                assign at_zero_vec[gi]   = 1'b1;
                assign underflow_vec[gi] = 1'b0;
            end else begin : g_cnt
                rv32i_sb_counter #(
                    .PEND_W (PEND_W)
                ) u_cnt (
                    .clk       (clk),
                    .reset     (reset),
                    .inc       (claim_ok && (issue_reg == AW'(gi))),
                    .dec       (wb_enable && (wb_reg == AW'(gi))),
                    .clr       (flush),
                    .count     (pend_cnt[gi]),
                    .at_max    (at_max_vec[gi]),
                    .at_zero   (at_zero_vec[gi]),
                    .underflow (underflow_vec[gi])
                );
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read ports with optional same-cycle forwarding from WB
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic            rd_hit;
            logic [XLEN-1:0] data_mux;

            assign rd_hit = (BYPASS != 0) && wb_enable && (wb_reg == rd_reg[gi]);

            always_comb begin
                data_mux = '0;
                if (rd_reg[gi] != '0) begin
                    data_mux = rd_hit ? wb_data : regs_reg[rd_reg[gi]];
                end
            end

            assign rd_data[gi] = data_mux;

            // The last outstanding write retiring right now is already
            // visible through the bypass, so the hazard is resolved.
            assign rd_busy[gi] = (rd_reg[gi] != '0) && !at_zero_vec[rd_reg[gi]] &&
                                 !(rd_hit && (pend_cnt[rd_reg[gi]] == PEND_W'(1)));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Sticky scoreboard error; retirements during a flush are not checked
    // because the claims they belonged to are being discarded.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_err_reg <= 1'b0;
        end else if (!flush && (|underflow_vec)) begin
            sb_err_reg <= 1'b1;
        end
    end

    assign sb_err = sb_err_reg;

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
module tb_rv32i_regfile_sb;
    import rv32i_pkg::*;

    localparam int SEL_RD0    = 0;
    localparam int SEL_RD1    = 1;
    localparam int SEL_BUSY0  = 2;
    localparam int SEL_BUSY1  = 3;
    localparam int SEL_READY  = 4;
    localparam int SEL_SBERR  = 5;
    localparam int SEL_NB_RD0 = 6;
    localparam int SEL_NB_B0  = 7;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } res_t;

    logic                  clk;
    logic                  reset;
    logic [1:0][REG_AW-1:0] rd_reg;
    logic [1:0][31:0]      rd_data;
    logic [1:0][31:0]      rd_data_nb;
    logic [1:0]            rd_busy;
    logic [1:0]            rd_busy_nb;
    logic                  issue_en;
    reg_idx_t              issue_reg;
    logic                  issue_ready;
    logic                  issue_ready_nb;
    logic                  wb_enable;
    reg_idx_t              wb_reg;
    word_t                 wb_data;
    logic                  flush;
    logic                  sb_err;
    logic                  sb_err_nb;

    exp_t exp_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rv32i_regfile_sb #(
        .XLEN(32), .NREGS(32), .NRD(2), .PEND_W(2), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset), .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_en(issue_en), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .sb_err(sb_err)
    );

    rv32i_regfile_sb #(
        .XLEN(32), .NREGS(32), .NRD(2), .PEND_W(2), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .reset(reset), .rd_reg(rd_reg), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .issue_en(issue_en), .issue_reg(issue_reg), .issue_ready(issue_ready_nb),
        .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .sb_err(sb_err_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD0:    return rd_data[0];
            SEL_RD1:    return rd_data[1];
            SEL_BUSY0:  return {31'd0, rd_busy[0]};
            SEL_BUSY1:  return {31'd0, rd_busy[1]};
            SEL_READY:  return {31'd0, issue_ready};
            SEL_SBERR:  return {31'd0, sb_err};
            SEL_NB_RD0: return rd_data_nb[0];
            SEL_NB_B0:  return {31'd0, rd_busy_nb[0]};
            default:    return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Wait to mid-cycle sample point, then pair every pending expectation
    // with what the DUT shows now.
    task automatic snap();
        exp_t e;
        res_t r;
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            r.name = e.name;
            r.got  = observe(e.sel);
            r.exp  = e.val;
            res_q.push_back(r);
        end
    endtask

    task automatic step(input logic ie, input logic [4:0] ir, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input logic fl,
                        input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        issue_en  = ie;
        issue_reg = ir;
        wb_enable = we;
        wb_reg    = wr;
        wb_data   = wd;
        flush     = fl;
        rd_reg[0] = r0;
        rd_reg[1] = r1;
    endtask

    task automatic test_reset();
        res_t r;
        reset = 1'b0;
        step(0, 5'd3, 0, 5'd0, 32'd0, 0, 5'd5, 5'd7);
        step(0, 5'd3, 0, 5'd0, 32'd0, 0, 5'd5, 5'd7);
        expect_val("reset_rd0", SEL_RD0, 32'd0);
        expect_val("reset_rd1", SEL_RD1, 32'd0);
        expect_val("reset_busy0", SEL_BUSY0, 32'd0);
        expect_val("reset_busy1", SEL_BUSY1, 32'd0);
        expect_val("reset_ready", SEL_READY, 32'd1);
        expect_val("reset_sberr", SEL_SBERR, 32'd0);
        expect_val("reset_nb_rd0", SEL_NB_RD0, 32'd0);
        snap();
        while (res_q.size() != 0) begin
            r = res_q.pop_front();
            n_checks++;
            if (r.got !== r.exp) $display("FAIL %s: got %h expected %h", r.name, r.got, r.exp);
            else begin n_pass++; $display("check %s: got %h", r.name, r.got); end
        end
    endtask

    task automatic test_bypass();
        res_t r;
        reset = 1'b1;
        step(1, 5'd5, 0, 5'd0, 32'd0, 0, 5'd5, 5'd0);
        step(1, 5'd5, 1, 5'd5, 32'h12345678, 0, 5'd5, 5'd0);
        expect_val("byp_ready_claim_retire", SEL_READY, 32'd1);
        expect_val("byp_busy0_last", SEL_BUSY0, 32'd0);
        expect_val("byp_rd0_first", SEL_RD0, 32'h12345678);
        snap();
        step(0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0);
        expect_val("byp_rd0_fwd", SEL_RD0, 32'hDEADBEEF);
        expect_val("byp_rd1_x0", SEL_RD1, 32'd0);
        expect_val("byp_nb_rd0_old", SEL_NB_RD0, 32'h12345678);
        expect_val("byp_busy0_fwd", SEL_BUSY0, 32'd0);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd5, 5'd0);
        expect_val("byp_rd0_after", SEL_RD0, 32'hDEADBEEF);
        expect_val("byp_nb_rd0_after", SEL_NB_RD0, 32'hDEADBEEF);
        expect_val("byp_sberr", SEL_SBERR, 32'd0);
        snap();
        while (res_q.size() != 0) begin
            r = res_q.pop_front();
            n_checks++;
            if (r.got !== r.exp) $display("FAIL %s: got %h expected %h", r.name, r.got, r.exp);
            else begin n_pass++; $display("check %s: got %h", r.name, r.got); end
        end
    endtask

    task automatic test_scoreboard();
        res_t r;
        step(1, 5'd7, 0, 5'd0, 32'd0, 0, 5'd7, 5'd7);
        step(1, 5'd7, 0, 5'd0, 32'd0, 0, 5'd7, 5'd7);
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd7, 5'd7);
        expect_val("sb_busy_p2", SEL_BUSY0, 32'd1);
        snap();
        step(0, 5'd0, 1, 5'd7, 32'h77, 0, 5'd7, 5'd7);
        expect_val("sb_busy_retire_p2", SEL_BUSY1, 32'd1);
        expect_val("sb_rd0_fwd77", SEL_RD0, 32'h77);
        snap();
        step(0, 5'd0, 1, 5'd7, 32'h78, 0, 5'd7, 5'd7);
        expect_val("sb_busy_retire_p1", SEL_BUSY0, 32'd0);
        expect_val("sb_nb_busy_retire_p1", SEL_NB_B0, 32'd1);
        expect_val("sb_rd0_fwd78", SEL_RD0, 32'h78);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd7, 5'd7);
        expect_val("sb_busy_p0", SEL_BUSY0, 32'd0);
        expect_val("sb_rd0_78", SEL_RD0, 32'h78);
        expect_val("sb_sberr", SEL_SBERR, 32'd0);
        snap();
        while (res_q.size() != 0) begin
            r = res_q.pop_front();
            n_checks++;
            if (r.got !== r.exp) $display("FAIL %s: got %h expected %h", r.name, r.got, r.exp);
            else begin n_pass++; $display("check %s: got %h", r.name, r.got); end
        end
    endtask

    task automatic test_saturation();
        res_t r;
        for (int k = 0; k < 3; k++) begin
            step(1, 5'd3, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3);
            expect_val($sformatf("sat_ready_claim%0d", k), SEL_READY, 32'd1);
            snap();
        end
        step(0, 5'd3, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3);
        expect_val("sat_ready_full", SEL_READY, 32'd0);
        expect_val("sat_busy_full", SEL_BUSY1, 32'd1);
        snap();
        step(1, 5'd3, 1, 5'd3, 32'h33, 0, 5'd0, 5'd3);
        expect_val("sat_ready_with_retire", SEL_READY, 32'd1);
        expect_val("sat_busy_p3_retire", SEL_BUSY1, 32'd1);
        snap();
        step(0, 5'd3, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3);
        expect_val("sat_ready_still_full", SEL_READY, 32'd0);
        snap();
        step(1, 5'd3, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3);
        step(0, 5'd3, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3);
        expect_val("sat_no_wrap", SEL_READY, 32'd0);
        snap();
        while (res_q.size() != 0) begin
            r = res_q.pop_front();
            n_checks++;
            if (r.got !== r.exp) $display("FAIL %s: got %h expected %h", r.name, r.got, r.exp);
            else begin n_pass++; $display("check %s: got %h", r.name, r.got); end
        end
    endtask

    task automatic test_flush();
        res_t r;
        step(1, 5'd1, 0, 5'd0, 32'd0, 0, 5'd1, 5'd2);
        step(1, 5'd2, 0, 5'd0, 32'd0, 0, 5'd1, 5'd2);
        step(1, 5'd4, 1, 5'd1, 32'h11, 1, 5'd1, 5'd2);
        expect_val("fl_busy_x1_retiring", SEL_BUSY0, 32'd0);
        expect_val("fl_busy_x2_pending", SEL_BUSY1, 32'd1);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd1, 5'd2);
        expect_val("fl_busy_x1", SEL_BUSY0, 32'd0);
        expect_val("fl_busy_x2", SEL_BUSY1, 32'd0);
        expect_val("fl_rd_x1", SEL_RD0, 32'h11);
        expect_val("fl_sberr", SEL_SBERR, 32'd0);
        snap();
        step(0, 5'd3, 0, 5'd0, 32'd0, 0, 5'd4, 5'd3);
        expect_val("fl_claim_dropped", SEL_BUSY0, 32'd0);
        expect_val("fl_busy_x3", SEL_BUSY1, 32'd0);
        expect_val("fl_ready_x3", SEL_READY, 32'd1);
        snap();
        step(0, 5'd0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd0);
        expect_val("fl_rd_x9_fwd", SEL_RD0, 32'h99);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd9, 5'd0);
        expect_val("fl_no_err_on_flush", SEL_SBERR, 32'd0);
        expect_val("fl_rd_x9", SEL_RD0, 32'h99);
        snap();
        while (res_q.size() != 0) begin
            r = res_q.pop_front();
            n_checks++;
            if (r.got !== r.exp) $display("FAIL %s: got %h expected %h", r.name, r.got, r.exp);
            else begin n_pass++; $display("check %s: got %h", r.name, r.got); end
        end
    endtask

    task automatic test_errors();
        res_t r;
        step(0, 5'd0, 1, 5'd0, 32'hFFFF, 0, 5'd0, 5'd0);
        expect_val("err_x0_rd0", SEL_RD0, 32'd0);
        expect_val("err_x0_rd1", SEL_RD1, 32'd0);
        snap();
        step(1, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        expect_val("err_x0_ready", SEL_READY, 32'd1);
        expect_val("err_x0_busy", SEL_BUSY0, 32'd0);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        expect_val("err_x0_no_err", SEL_SBERR, 32'd0);
        expect_val("err_x0_busy_after", SEL_BUSY0, 32'd0);
        snap();
        step(0, 5'd0, 1, 5'd10, 32'hAA, 0, 5'd10, 5'd0);
        expect_val("err_not_yet", SEL_SBERR, 32'd0);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd10, 5'd0);
        expect_val("err_set", SEL_SBERR, 32'd1);
        expect_val("err_rd_x10", SEL_RD0, 32'hAA);
        snap();
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd10, 5'd0);
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd10, 5'd0);
        expect_val("err_sticky", SEL_SBERR, 32'd1);
        snap();
        reset = 1'b0;
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd10, 5'd0);
        reset = 1'b1;
        step(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd10, 5'd0);
        expect_val("err_cleared_by_reset", SEL_SBERR, 32'd0);
        expect_val("err_rd_x10_reset", SEL_RD0, 32'd0);
        snap();
        while (res_q.size() != 0) begin
            r = res_q.pop_front();
            n_checks++;
            if (r.got !== r.exp) $display("FAIL %s: got %h expected %h", r.name, r.got, r.exp);
            else begin n_pass++; $display("check %s: got %h", r.name, r.got); end
        end
    endtask

    initial begin
        reset     = 1'b0;
        issue_en  = 1'b0;
        issue_reg = '0;
        wb_enable = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        flush     = 1'b0;
        rd_reg[0] = '0;
        rd_reg[1] = '0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_saturation();
        test_flush();
        test_errors();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
